f3_rd_sched: RTL and testbench
==============================

Name: f3_rd_sched

Overview:
- Controller for the S2→C3 feature buffer: a 6-channel × 16-bit, 256-deep, 1-cycle-read-latency dual-port RAM.
- Write side: counts incoming pooled pixels into write addresses until one 14×14 map set is stored.
- Read side: on start, sweeps every 5×5 window over the 10×10 C3 output grid and issues read addresses.
- Emits a valid/tap-marker stream aligned with RAM read data so the C3 MAC array can consume it directly.

Parameters:
- MAP_W, 14, input map width and height (square).
- K, 5, convolution kernel size.
- AW, 8, RAM address width. MAP_W*MAP_W must be ≤ 2**AW; compile-time check required.

Ports:
- clk  in  1  single clock for both RAM ports and this block
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort: return to IDLE, empty the buffer
- wr_valid  in  1  pooled 6-channel pixel present on RAM write data this cycle
- f3_wr_en  out  1  RAM write enable
- f3_waddr  out  AW  RAM write address
- map_full  out  1  full map stored; buffer locked against writes
- wr_overflow  out  1  sticky: wr_valid seen while map_full; cleared by clear or reset
- start  in  1  begin window scan (single-cycle pulse)
- busy  out  1  scan in progress
- f3_raddr  out  AW  RAM read address (registered)
- rd_valid  out  1  RAM read data valid this cycle
- tap_first  out  1  with rd_valid: first tap (ky=0,kx=0) of a window
- tap_last  out  1  with rd_valid: last tap (ky=K-1,kx=K-1) of a window
- out_row  out  4  output row of the current window, aligned with rd_valid
- out_col  out  4  output column of the current window, aligned with rd_valid
- done  out  1  one-cycle pulse coincident with the final rd_valid

Behaviour:
- Reset values:
  - States: FSM=IDLE; write count=0.
  - Outputs: f3_waddr=0, f3_raddr=0, map_full=0, wr_overflow=0, busy=0, rd_valid=0, tap_first=0, tap_last=0, out_row=0, out_col=0, done=0.
- States: IDLE, SCAN, DRAIN.
- Write side:
  - f3_wr_en = wr_valid & ~map_full (combinational).
  - f3_waddr increments after each accepted write.
  - On the write to address MAP_W*MAP_W-1 (195): map_full←1 next cycle and f3_waddr←0.
  - wr_valid while map_full: no write, wr_overflow←1.
- IDLE→SCAN: on start & map_full. Otherwise start is ignored; it is not queued.
- SCAN address generation:
  - Counters oy, ox in 0..OUT_W-1 (OUT_W = MAP_W-K+1 = 10); ky, kx in 0..K-1.
  - Order: kx fastest, then ky, then ox, then oy.
  - f3_raddr = (oy+ky)*MAP_W + (ox+kx), maintained incrementally (adds only; no multiplier).
  - One address per cycle, no stalls.
- Timing (start accepted at cycle 0):
  - First raddr valid at cycle 1.
  - Address for tap n is issued at cycle n+1.
  - rd_valid, tap_first, tap_last, out_row, out_col are delayed one cycle to match RAM latency, so tap n's data appears at cycle n+2.
- Scan length: 10·10·25 = 2500 addresses; rd_valid high for cycles 2..2501 continuously.
- End of scan:
  - After the final address is issued, SCAN→DRAIN for 1 cycle.
  - done pulses with the final rd_valid (cycle 2501).
  - Same cycle, map_full←0 and waddr←0.
  - Next state IDLE; busy falls in cycle 2502.
- Overlap: writes for the next map are blocked until map_full clears. No ping-pong.
- clear: highest priority over all events, including a simultaneous start or write.
  - Next cycle: IDLE, counters 0, map_full=0, wr_overflow=0, rd_valid=0.
  - No done pulse.
- rst_n low mid-scan: immediate return to reset values. RAM contents are not cleared; the buffer is treated as empty.

Decomposition:
- Package f3_pkg holds:
  - constants MAP_W, K, OUT_W, MAP_SZ = MAP_W*MAP_W, TAPS = K*K;
  - the state enum {IDLE, SCAN, DRAIN}.
- One sub-module, f3_win_addr_gen, contains:
  - the oy/ox/ky/kx counters, incremental address, and last-tap/last-window flags;
  - the advance-enable input.
- The top level holds the FSM, write counter, and the 1-cycle alignment register stage.

Test Plan:
- Write 196 pixels back-to-back → f3_waddr 0..195, map_full=1 the cycle after the 196th write; a 197th wr_valid → f3_wr_en=0, wr_overflow=1.
- start with map_full=0 → busy stays 0, no raddr activity; then fill and start → first raddrs 0,1,2,3,4,14,15, with tap_first on the first rd_valid at cycle 2.
- Full scan → exactly 2500 rd_valid cycles with no gaps. Window (0,1) taps start at addr 1; the last window (9,9) starts at addr 135 and ends at addr 195. tap_last count = 100; done at cycle 2501; map_full clears.
- clear asserted at cycle 700 of a scan → rd_valid=0 next cycle, no done, map_full=0; a refill plus start yields a correct full scan.
- rst_n pulsed low mid-fill (waddr=50) → all outputs at reset values asynchronously; the next write lands at addr 0.
- start and clear in the same cycle with map_full=1 → IDLE, map_full=0, busy stays 0.

Source files
------------

// File: rtl/f3_pkg.sv
// Shared constants and types for the S2->C3 feature-buffer controller.
// MAP_W/K describe the stored input map and the convolution window; OUT_W is the
// number of valid window positions per axis; AW_DEF is the default RAM address width.
package f3_pkg;

  localparam int unsigned MAP_W  = 14;
  localparam int unsigned K      = 5;
  localparam int unsigned OUT_W  = MAP_W - K + 1;
  localparam int unsigned MAP_SZ = MAP_W * MAP_W;
  localparam int unsigned TAPS   = K * K;
  localparam int unsigned AW_DEF = 8;

  // Width of the ky/kx tap counters.
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } f3_state_e;

endpackage

// File: rtl/f3_win_addr_gen.sv
// Window/tap address generator for the C3 read sweep.
// Walks kx fastest, then ky, then ox, then oy, and keeps the RAM address
// (oy+ky)*MAP_W + (ox+kx) up to date with adders only.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           return all counters to the first tap of the first window
//   adv_i           step to the next tap (wraps to the start after the last one)
//   addr_o          RAM read address of the current tap (registered)
//   oy_o, ox_o      output row/column of the current window
//   tap_first_o     current tap is (ky=0, kx=0)
//   tap_last_o      current tap is (ky=K-1, kx=K-1)
//   last_win_o      current window is (OUT_W-1, OUT_W-1)
module f3_win_addr_gen
  import f3_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [AW-1:0] addr_o,
  output logic [3:0]    oy_o,
  output logic [3:0]    ox_o,
  output logic          tap_first_o,
  output logic          tap_last_o,
  output logic          last_win_o
);

  localparam logic [KW-1:0] KMax = KW'(K - 1);
  localparam logic [3:0]    OMax = 4'(OUT_W - 1);
  localparam logic [AW-1:0] Step = AW'(MAP_W);
  localparam logic [AW-1:0] One  = AW'(1);

  logic [3:0]    oy_q, oy_d, ox_q, ox_d;
  logic [KW-1:0] ky_q, ky_d, kx_q, kx_d;
  // base: oy*MAP_W; win: window origin; row: start of the current tap row.
  logic [AW-1:0] base_q, base_d, win_q, win_d, row_q, row_d, addr_q, addr_d;

  logic last_kx, last_ky, last_ox, last_oy;

  assign last_kx = (kx_q == KMax);
  assign last_ky = (ky_q == KMax);
  assign last_ox = (ox_q == OMax);
  assign last_oy = (oy_q == OMax);

  always_comb begin
    oy_d   = oy_q;
    ox_d   = ox_q;
    ky_d   = ky_q;
    kx_d   = kx_q;
    base_d = base_q;
    win_d  = win_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr_i) begin
      oy_d   = '0;
      ox_d   = '0;
      ky_d   = '0;
      kx_d   = '0;
      base_d = '0;
      win_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (adv_i) begin
      if (!last_kx) begin
        kx_d   = kx_q + KW'(1);
        addr_d = addr_q + One;
      end else if (!last_ky) begin
        kx_d   = '0;
        ky_d   = ky_q + KW'(1);
        row_d  = row_q + Step;
        addr_d = row_q + Step;
      end else if (!last_ox) begin
        kx_d   = '0;
        ky_d   = '0;
        ox_d   = ox_q + 4'd1;
        win_d  = win_q + One;
        row_d  = win_q + One;
        addr_d = win_q + One;
      end else if (!last_oy) begin
        kx_d   = '0;
        ky_d   = '0;
        ox_d   = '0;
        oy_d   = oy_q + 4'd1;
        base_d = base_q + Step;
        win_d  = base_q + Step;
        row_d  = base_q + Step;
        addr_d = base_q + Step;
      end else begin
        // Final tap of the final window: wrap so the next scan starts clean.
        oy_d   = '0;
        ox_d   = '0;
        ky_d   = '0;
        kx_d   = '0;
        base_d = '0;
        win_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oy_q   <= '0;
      ox_q   <= '0;
      ky_q   <= '0;
      kx_q   <= '0;
      base_q <= '0;
      win_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      oy_q   <= oy_d;
      ox_q   <= ox_d;
      ky_q   <= ky_d;
      kx_q   <= kx_d;
      base_q <= base_d;
      win_q  <= win_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o      = addr_q;
  assign oy_o        = oy_q;
  assign ox_o        = ox_q;
  assign tap_first_o = (kx_q == '0) && (ky_q == '0);
  assign tap_last_o  = last_kx && last_ky;
  assign last_win_o  = last_ox && last_oy;

endmodule

// File: rtl/f3_rd_sched.sv
// S2->C3 feature-buffer controller.
// Write side counts pooled pixels into RAM write addresses until one MAP_W x MAP_W
// map is stored, then locks the buffer. On start, the read side sweeps every KxK
// window of the OUT_W x OUT_W output grid, one address per cycle, and emits a
// valid/tap-marker stream delayed one cycle to line up with RAM read data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort; returns to idle and empties the buffer
//   wr_valid            pooled pixel present on RAM write data
//   f3_wr_en, f3_waddr  RAM write port control
//   map_full            full map stored, writes blocked
//   wr_overflow         sticky: write attempted while full
//   start               begin a window scan (ignored unless map_full)
//   busy                scan or drain in progress
//   f3_raddr            RAM read address (registered)
//   rd_valid, tap_first, tap_last, out_row, out_col  stream aligned with read data
//   done                pulse with the final rd_valid of a scan
module f3_rd_sched
  import f3_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_valid,
  output logic          f3_wr_en,
  output logic [AW-1:0] f3_waddr,
  output logic          map_full,
  output logic          wr_overflow,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] f3_raddr,
  output logic          rd_valid,
  output logic          tap_first,
  output logic          tap_last,
  output logic [3:0]    out_row,
  output logic [3:0]    out_col,
  output logic          done
);

  if (MAP_SZ > (1 << AW)) begin : g_aw_chk
    $error("f3_rd_sched: MAP_W*MAP_W does not fit in 2**AW RAM words");
  end
  if (OUT_W > 16) begin : g_ow_chk
    $error("f3_rd_sched: OUT_W exceeds the 4-bit out_row/out_col range");
  end

  localparam logic [AW-1:0] LastWaddr = AW'(MAP_SZ - 1);

  f3_state_e     state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic          tap_first_q, tap_first_d;
  logic          tap_last_q, tap_last_d;
  logic [3:0]    row_q, row_d, col_q, col_d;
  logic          done_q, done_d;

  logic          gen_adv, gen_clr, issue;
  logic [AW-1:0] gen_addr;
  logic [3:0]    gen_oy, gen_ox;
  logic          gen_first, gen_last, gen_last_win;

  f3_win_addr_gen #(
    .AW (AW)
  ) u_addr_gen (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (gen_clr),
    .adv_i       (gen_adv),
    .addr_o      (gen_addr),
    .oy_o        (gen_oy),
    .ox_o        (gen_ox),
    .tap_first_o (gen_first),
    .tap_last_o  (gen_last),
    .last_win_o  (gen_last_win)
  );

  // FSM: clear overrides everything, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    gen_adv = 1'b0;
    gen_clr = 1'b0;
    if (clear) begin
      state_d = StIdle;
      gen_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && full_q) begin
            state_d = StScan;
            gen_clr = 1'b1;
          end
        end
        StScan: begin
          gen_adv = 1'b1;
          if (gen_last && gen_last_win) state_d = StDrain;
        end
        StDrain: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // An address is issued in every SCAN cycle; its data returns one cycle later.
  assign issue = (state_q == StScan) && !clear;

  always_comb begin
    rd_valid_d  = issue;
    tap_first_d = issue && gen_first;
    tap_last_d  = issue && gen_last;
    row_d       = issue ? gen_oy : 4'd0;
    col_d       = issue ? gen_ox : 4'd0;
    done_d      = issue && gen_last && gen_last_win;
  end

  assign f3_wr_en = wr_valid && !full_q;

  always_comb begin
    waddr_d = waddr_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    if (clear) begin
      waddr_d = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (f3_wr_en) begin
        if (waddr_q == LastWaddr) begin
          waddr_d = '0;
          full_d  = 1'b1;
        end else begin
          waddr_d = waddr_q + AW'(1);
        end
      end
      if (wr_valid && full_q) ovf_d = 1'b1;
      // Buffer is released as the final read data is delivered.
      if (state_q == StDrain) begin
        full_d  = 1'b0;
        waddr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      tap_first_q <= tap_first_d;
      tap_last_q  <= tap_last_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
    end
  end

  assign f3_waddr    = waddr_q;
  assign map_full    = full_q;
  assign wr_overflow = ovf_q;
  assign busy        = (state_q != StIdle);
  assign f3_raddr    = gen_addr;
  assign rd_valid    = rd_valid_q;
  assign tap_first   = tap_first_q;
  assign tap_last    = tap_last_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign done        = done_q;

endmodule

// File: tb/tb_f3_rd_sched.sv
// Bench for f3_rd_sched: a behavioural RAM sits on the write/read ports, each
// written word carries {fill tag, write index}, and a scoreboard of expected
// {data, tap_first, tap_last, row, col} tuples is pushed when a scan is started
// and popped on every rd_valid.
module tb_f3_rd_sched;
  import f3_pkg::*;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic          start = 1'b0;
  logic          f3_wr_en;
  logic [AW-1:0] f3_waddr;
  logic          map_full;
  logic          wr_overflow;
  logic          busy;
  logic [AW-1:0] f3_raddr;
  logic          rd_valid;
  logic          tap_first;
  logic          tap_last;
  logic [3:0]    out_row;
  logic [3:0]    out_col;
  logic          done;

  logic [15:0]   wdata = '0;
  logic [15:0]   rdata;
  logic [15:0]   mem [256];

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   sb [$];
  logic [31:0]   sb_exp;

  f3_rd_sched #(
    .AW (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .wr_valid    (wr_valid),
    .f3_wr_en    (f3_wr_en),
    .f3_waddr    (f3_waddr),
    .map_full    (map_full),
    .wr_overflow (wr_overflow),
    .start       (start),
    .busy        (busy),
    .f3_raddr    (f3_raddr),
    .rd_valid    (rd_valid),
    .tap_first   (tap_first),
    .tap_last    (tap_last),
    .out_row     (out_row),
    .out_col     (out_col),
    .done        (done)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency dual-port RAM.
  always @(posedge clk) begin
    if (f3_wr_en) mem[f3_waddr] <= wdata;
    rdata <= mem[f3_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        sb_exp = sb.pop_front();
        check_eq("rd_stream", {rdata, 6'd0, tap_first, tap_last, out_row, out_col}, sb_exp);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [7:0] tag);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wdata    = {tag, 8'(k)};
      @(negedge clk);
      check_eq("waddr", 32'(f3_waddr), 32'(k));
      check_eq("wr_en", 32'(f3_wr_en), 32'd1);
      sync();
    end
    wr_valid = 1'b0;
  endtask

  task automatic push_expected(input logic [7:0] tag);
    for (int oy = 0; oy < int'(OUT_W); oy++)
      for (int ox = 0; ox < int'(OUT_W); ox++)
        for (int ky = 0; ky < int'(K); ky++)
          for (int kx = 0; kx < int'(K); kx++) begin
            int  a;
            logic f, l;
            a = (oy + ky) * int'(MAP_W) + ox + kx;
            f = (ky == 0) && (kx == 0);
            l = (ky == int'(K) - 1) && (kx == int'(K) - 1);
            sb.push_back({tag, 8'(a), 6'd0, f, l, 4'(oy), 4'(ox)});
          end
  endtask

  task automatic run_scan(input logic [7:0] tag);
    int exp_ra [7] = '{0, 1, 2, 3, 4, 14, 15};
    int rv_cnt = 0, tl_cnt = 0, done_cnt = 0;
    int first_rv = -1, last_rv = -1, done_cyc = -1;
    push_expected(tag);
    start = 1'b1;
    sync();
    start = 1'b0;
    for (int c = 1; c <= 2505; c++) begin
      @(negedge clk);
      if (c <= 7) check_eq("first_raddrs", 32'(f3_raddr), 32'(exp_ra[c-1]));
      if (c == 1) check_eq("busy_c1", 32'(busy), 32'd1);
      if (c == 2) check_eq("tap_first_c2", {31'd0, rd_valid & tap_first}, 32'd1);
      if (c == 2501) check_eq("busy_c2501", 32'(busy), 32'd1);
      if (c == 2502) begin
        check_eq("busy_c2502", 32'(busy), 32'd0);
        check_eq("map_full_released", 32'(map_full), 32'd0);
        check_eq("waddr_after_scan", 32'(f3_waddr), 32'd0);
      end
      if (rd_valid) begin
        rv_cnt++;
        if (first_rv < 0) first_rv = c;
        last_rv = c;
        if (tap_last) tl_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    check_eq("rd_valid_count", 32'(rv_cnt), 32'd2500);
    check_eq("rd_valid_first_cycle", 32'(first_rv), 32'd2);
    check_eq("rd_valid_no_gaps", 32'(last_rv - first_rv + 1), 32'(rv_cnt));
    check_eq("tap_last_count", 32'(tl_cnt), 32'd100);
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("done_cycle", 32'(done_cyc), 32'd2501);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    sync();
  endtask

  task automatic abort_scan(input logic [7:0] tag);
    int bad = 0;
    push_expected(tag);
    start = 1'b1;
    sync();
    start = 1'b0;
    for (int c = 1; c <= 699; c++) @(negedge clk);
    sync();
    clear = 1'b1;  // held through cycle 700
    sync();
    clear = 1'b0;
    @(negedge clk);
    check_eq("abort_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("abort_map_full", 32'(map_full), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_raddr", 32'(f3_raddr), 32'd0);
    check_eq("abort_ovf_cleared", 32'(wr_overflow), 32'd0);
    sb.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || rd_valid || busy) bad++;
    end
    check_eq("abort_quiet", 32'(bad), 32'd0);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    #12;
    rst_n = 1'b1;
    sync();
    check_eq("rst_waddr_raddr", {f3_waddr, f3_raddr}, '0);
    check_eq("rst_flags", {map_full, wr_overflow, busy, rd_valid, tap_first, tap_last, done}, '0);
    check_eq("rst_row_col", {out_row, out_col}, '0);

    // start without a stored map is ignored
    start = 1'b1;
    sync();
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || f3_raddr != '0) bad++;
    end
    check_eq("start_ignored", 32'(bad), 32'd0);
    sync();

    // full fill, then overflow attempt
    fill(196, 8'h11);
    @(negedge clk);
    check_eq("map_full_set", 32'(map_full), 32'd1);
    check_eq("waddr_wrapped", 32'(f3_waddr), 32'd0);
    sync();
    wr_valid = 1'b1;
    wdata    = 16'hdead;
    @(negedge clk);
    check_eq("wr_en_blocked", 32'(f3_wr_en), 32'd0);
    sync();
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("wr_overflow_set", 32'(wr_overflow), 32'd1);
    sync();

    run_scan(8'h11);
    check_eq("ovf_sticky_after_scan", 32'(wr_overflow), 32'd1);

    // abort mid-scan, then refill and rescan
    fill(196, 8'h22);
    abort_scan(8'h22);
    fill(196, 8'h33);
    run_scan(8'h33);

    // asynchronous reset mid-fill
    fill(50, 8'h44);
    check_eq("waddr_mid_fill", 32'(f3_waddr), 32'd50);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_waddr", 32'(f3_waddr), 32'd0);
    check_eq("async_rst_flags", {map_full, wr_overflow, busy, rd_valid, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    fill(196, 8'h55);

    // start and clear together while full
    start = 1'b1;
    clear = 1'b1;
    sync();
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check_eq("sc_map_full", 32'(map_full), 32'd0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy) bad++;
      @(negedge clk);
    end
    check_eq("sc_busy_low", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
